esl_stream_decoder: RTL and testbench

//  Consumes the registered ESL bitstream pair (x, y) produced by a processing element.

---
 rtl/esl_pkg.sv | 19 +
 rtl/esl_seq_divider.sv | 56 +++++
 rtl/esl_stream_decoder.sv | 156 +++++++++++++++
 tb/tb_esl_stream_decoder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/esl_pkg.sv
// Shared types and helpers for the ESL stochastic-to-binary back ends.
package esl_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} esl_dec_state_t;

  localparam int DEFAULT_BIN_LEN = 4;
  localparam int DEFAULT_FRAC_BITS = 8;
  localparam int N = 1 << DEFAULT_BIN_LEN;
  localparam int QW = DEFAULT_BIN_LEN + 1 + DEFAULT_FRAC_BITS;

  function automatic int signed_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int signed_min(input int width);
    return -(1 << (width - 1));
  endfunction

endpackage

// File: rtl/esl_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses after DIVIDEND_W steps.
module esl_seq_divider #(
  parameter int DIVIDEND_W = 13,
  parameter int DIVISOR_W  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W-1:0] rem;
  logic [CNT_W-1:0]     cnt;
  logic                 active;
  logic [DIVISOR_W:0]   rem_sh;
  logic [DIVISOR_W:0]   trial;
  logic                 fits;

  // The quotient register doubles as the dividend shift register.
  always_comb begin
    rem_sh = {rem, quotient[DIVIDEND_W-1]};
    trial  = rem_sh - {1'b0, divisor};
    fits   = (rem_sh >= {1'b0, divisor});
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem      <= '0;
      cnt      <= '0;
      active   <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quotient <= dividend;
        rem      <= '0;
        cnt      <= CNT_W'(DIVIDEND_W);
        active   <= 1'b1;
      end else if (active) begin
        quotient <= {quotient[DIVIDEND_W-2:0], fits};
        rem      <= fits ? trial[DIVISOR_W-1:0] : rem_sh[DIVISOR_W-1:0];
        cnt      <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/esl_stream_decoder.sv
// Counts ones on a bipolar ESL stream pair over one window, then divides the
// bipolar counts into a saturated signed fixed-point result on valid/ready.
module esl_stream_decoder
  import esl_pkg::*;
#(
  parameter int BIN_LEN   = 4,
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             in_x,
  input  logic             in_y,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             div_zero,
  output logic             saturated
);
  localparam int WIN   = 1 << BIN_LEN;
  localparam int DQW   = BIN_LEN + 1 + FRAC_BITS;
  localparam int CNTW  = BIN_LEN + 1;
  localparam int SW    = BIN_LEN + 2;
  localparam int MAXV  = signed_max(OUT_W);
  localparam int CW    = (DQW > OUT_W) ? DQW : OUT_W;
  localparam logic [CNTW-1:0] LAST = CNTW'(WIN - 1);

  esl_dec_state_t  state;
  logic [CNTW-1:0] cnt_x, cnt_y, win_cnt;
  logic            setup, sign;

  logic [SW-1:0]    num, den, num_abs, den_abs;
  logic [DQW-1:0]   dividend, quotient;
  logic [CNTW-1:0]  divisor;
  logic             div_start, div_done;
  logic [CW-1:0]    quo_ext;
  logic             ovf;
  logic [OUT_W-1:0] mag_clip, res_div, res_max, res_min;

  // Bipolar counts 2*cnt - N; the MSB is the sign.
  always_comb begin
    num       = {cnt_x, 1'b0} - SW'(WIN);
    den       = {cnt_y, 1'b0} - SW'(WIN);
    num_abs   = num[SW-1] ? (~num + 1'b1) : num;
    den_abs   = den[SW-1] ? (~den + 1'b1) : den;
    dividend  = DQW'({num_abs, {FRAC_BITS{1'b0}}});
    divisor   = CNTW'(den_abs);
    div_start = (state == DIVIDE) && setup && (den != '0) && (num != '0);
    quo_ext   = CW'(quotient);
    ovf       = (quo_ext > CW'(MAXV));
    mag_clip  = ovf ? OUT_W'(MAXV) : OUT_W'(quo_ext);
    res_div   = sign ? (~mag_clip + 1'b1) : mag_clip;
    res_max   = OUT_W'(MAXV);
    res_min   = ~res_max + 1'b1;
  end

  esl_seq_divider #(
    .DIVIDEND_W(DQW),
    .DIVISOR_W (CNTW)
  ) u_div (
    .clock   (clock),
    .reset   (reset),
    .start   (div_start),
    .dividend(dividend),
    .divisor (divisor),
    .done    (div_done),
    .quotient(quotient)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      div_zero  <= 1'b0;
      saturated <= 1'b0;
      cnt_x     <= '0;
      cnt_y     <= '0;
      win_cnt   <= '0;
      setup     <= 1'b0;
      sign      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ACCUM;
            busy    <= 1'b1;
            cnt_x   <= '0;
            cnt_y   <= '0;
            win_cnt <= '0;
          end
        end
        ACCUM: begin
          if (enable) begin
            cnt_x   <= cnt_x + CNTW'(in_x);
            cnt_y   <= cnt_y + CNTW'(in_y);
            win_cnt <= win_cnt + 1'b1;
            if (win_cnt == LAST) begin
              state <= DIVIDE;
              setup <= 1'b1;
            end
          end
        end
        DIVIDE: begin
          if (setup) begin
            setup <= 1'b0;
            sign  <= num[SW-1] ^ den[SW-1];
            // Degenerate cases finish immediately without running the divider.
            if (den == '0) begin
              out_data  <= num[SW-1] ? res_min : res_max;
              div_zero  <= 1'b1;
              saturated <= 1'b1;
              out_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end else if (num == '0) begin
              out_data  <= '0;
              div_zero  <= 1'b0;
              saturated <= 1'b0;
              out_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end
          end else if (div_done) begin
            out_data  <= res_div;
            div_zero  <= 1'b0;
            saturated <= ovf;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              state   <= ACCUM;
              busy    <= 1'b1;
              cnt_x   <= '0;
              cnt_y   <= '0;
              win_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_esl_stream_decoder.sv
// Randomised and directed windows on two decoder instances (16-bit and 12-bit results).
module tb_esl_stream_decoder;
  logic clock = 1'b0;
  logic reset, enable, start, in_x, in_y, out_ready;
  logic busy, out_valid, div_zero, saturated;
  logic [15:0] out_data;
  logic busy12, valid12, dz12, sat12;
  logic [11:0] data12;

  int total = 0;
  int passed = 0;

  always #5 clock = ~clock;

  esl_stream_decoder #(.BIN_LEN(4), .OUT_W(16), .FRAC_BITS(8)) dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .in_x(in_x), .in_y(in_y), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .div_zero(div_zero),
    .saturated(saturated)
  );

  esl_stream_decoder #(.BIN_LEN(4), .OUT_W(12), .FRAC_BITS(8)) dut12 (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .in_x(in_x), .in_y(in_y), .busy(busy12), .out_valid(valid12),
    .out_ready(out_ready), .out_data(data12), .div_zero(dz12),
    .saturated(sat12)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  // Reference: value = (2Nx-N)/(2Ny-N) in Q.8, truncated toward zero, clipped to +-MAX.
  function automatic void model(input int nx, input int ny, input int ow,
                                output logic [31:0] d, output logic dz, output logic sat);
    int num, den, mx, q;
    num = 2 * nx - 16;
    den = 2 * ny - 16;
    mx  = (1 << (ow - 1)) - 1;
    dz  = 1'b0;
    sat = 1'b0;
    if (den == 0) begin
      dz = 1'b1; sat = 1'b1;
      q = (num >= 0) ? mx : -mx;
    end else if (num == 0) begin
      q = 0;
    end else begin
      q = ((num < 0 ? -num : num) * 256) / (den < 0 ? -den : den);
      if (q > mx) begin q = mx; sat = 1'b1; end
      if ((num < 0) != (den < 0)) q = -q;
    end
    d = 32'(q) & ((32'd1 << ow) - 1);
  endfunction

  function automatic logic [15:0] make_bits(input int n);
    logic [15:0] v = '0;
    logic t;
    int j;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = v[i]; v[i] = v[j]; v[j] = t;
    end
    return v;
  endfunction

  task automatic do_start();
    @(negedge clock);
    start = 1'b1; enable = 1'b0;
  endtask

  // Feeds len enabled bits; gaps inserts random disabled cycles carrying junk.
  task automatic feed(input int nx, input int ny, input int len, input bit gaps, input bit poke);
    logic [15:0] xb, yb;
    int i = 0;
    xb = make_bits(nx);
    yb = make_bits(ny);
    while (i < len) begin
      @(negedge clock);
      start = poke && (i == 3 || i == 9);
      if (gaps && $urandom_range(1, 0) == 1) begin
        enable = 1'b0; in_x = 1'($urandom); in_y = 1'($urandom);
      end else begin
        enable = 1'b1; in_x = xb[i]; in_y = yb[i]; i++;
      end
    end
    @(negedge clock);
    start = 1'b0; enable = 1'($urandom); in_x = 1'($urandom); in_y = 1'($urandom);
  endtask

  logic [31:0] exp16, exp12;

  task automatic wait_result(input int nx, input int ny);
    logic dz_e, sat_e, dz_e12, sat_e12;
    int budget = 0;
    model(nx, ny, 16, exp16, dz_e, sat_e);
    model(nx, ny, 12, exp12, dz_e12, sat_e12);
    while (!out_valid && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    chk("valid_timeout", 32'(out_valid), 32'd1);
    chk("valid12", 32'(valid12), 32'd1);
    chk("data16", 32'(out_data), exp16);
    chk("dz16", 32'(div_zero), 32'(dz_e));
    chk("sat16", 32'(saturated), 32'(sat_e));
    chk("data12", 32'(data12), exp12);
    chk("dz12", 32'(dz12), 32'(dz_e12));
    chk("sat12", 32'(sat12), 32'(sat_e12));
    chk("busy_done", 32'(busy), 32'd0);
    $display("window nx=%0d ny=%0d data16=%h data12=%h dz=%0d sat16=%0d sat12=%0d",
             nx, ny, out_data, data12, div_zero, saturated, sat12);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      start = 1'b0; out_ready = 1'b0;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), exp16);
    end
  endtask

  task automatic handshake(input bit with_start);
    @(negedge clock);
    out_ready = 1'b1; start = with_start; enable = 1'b0;
    @(negedge clock);
    out_ready = 1'b0; start = 1'b0;
    chk("hs_valid_drop", 32'(out_valid), 32'd0);
    chk("hs_busy", 32'(busy), 32'(with_start));
    chk("hs_data_hold", 32'(out_data), exp16);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    chk("rst_sat", 32'(saturated), 32'd0);
    chk("rst_data12", 32'(data12), 32'd0);
  endtask

  task automatic full_window(input int nx, input int ny);
    do_start();
    feed(nx, ny, 16, 1'b0, 1'b0);
    wait_result(nx, ny);
    handshake(1'b0);
  endtask

  initial begin
    int dnx[7] = '{16, 12, 4, 12, 4, 16, 13};
    int dny[7] = '{16, 16, 12, 8, 8, 9, 15};
    int nx, ny;
    bit chained;

    reset = 1'b1; enable = 1'b0; start = 1'b0; in_x = 1'b0; in_y = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    apply_reset();

    for (int k = 0; k < 7; k++) full_window(dnx[k], dny[k]);

    // Gapped window with ignored start pulses, long stall, then chained start.
    do_start();
    feed(13, 15, 16, 1'b1, 1'b1);
    wait_result(13, 15);
    hold(20);
    handshake(1'b1);
    feed(12, 16, 16, 1'b0, 1'b0);
    wait_result(12, 16);
    handshake(1'b0);

    // Reset mid-window and mid-divide, each followed by a clean window.
    do_start();
    feed(10, 3, 7, 1'b0, 1'b0);
    apply_reset();
    full_window(4, 12);
    do_start();
    feed(15, 2, 16, 1'b0, 1'b0);
    repeat (5) @(negedge clock);
    apply_reset();
    full_window(13, 15);

    chained = 1'b0;
    for (int k = 0; k < 12; k++) begin
      nx = $urandom_range(16, 0);
      ny = $urandom_range(16, 0);
      if (!chained) do_start();
      feed(nx, ny, 16, 1'($urandom), 1'($urandom));
      wait_result(nx, ny);
      hold($urandom_range(3, 0));
      chained = 1'($urandom);
      handshake(chained);
    end
    if (chained) begin
      feed(8, 8, 16, 1'b0, 1'b0);
      wait_result(8, 8);
      handshake(1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
